arilla_bus_master: RTL and testbench
====================================

Name: arilla_bus_master

Overview:
- Initiator side of the arillaBus; drives ADDR/RD/WR and the shared tri-state DATA toward memory-mapped peripherals such as the UART/sound controller at 0x40000000-0x40000008.
- Accepts write, read and poll commands from a core-side valid/ready port and buffers them in a small command queue.
- Issues exactly one single-cycle bus access per RD/WR strobe, because peripheral FIFO pops/pushes fire on every clock edge where RD/WR is high.
- Returns one response pulse per command.

Parameters:
- DEPTH, 4, command queue entries (power of 2, >=2)
- POLL_GAP, 2, idle clk cycles between successive poll reads (>=0)
- POLL_MAX, 16, maximum reads per poll command before error (>=1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue not full; command accepted on edge where cmd_valid&&cmd_ready
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 reserved (accepted, completes with rsp_err=1, no bus access)
- cmd_addr  in  32  bus address
- cmd_data  in  32  write data (write) or match value (poll)
- cmd_mask  in  32  poll compare mask; ignored otherwise
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_data  out  32  read/poll sample; 0 for write
- rsp_err  out  1  poll timeout or reserved op
- busy  out  1  queue non-empty or FSM not IDLE
- ADDR  out  32  bus address, registered
- RD  out  1  read strobe, registered
- WR  out  1  write strobe, registered
- DATA  inout  32  driven with write data only while WR=1, else high-Z

Behaviour:
- Reset (async, rst_n=0):
  - Queue empty, FSM IDLE.
  - ADDR=0, RD=0, WR=0, DATA=Z.
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, cmd_ready=1.
  - Reset mid-transaction aborts it; no response is generated and queued commands are discarded.
- Queue:
  - FIFO with DEPTH entries; cmd_ready = !full (registered count).
  - Push and pop in the same cycle allowed when not full. When full, cmd_ready=0, so no push, even if a pop occurs that cycle.
- FSM states IDLE, ACCESS, RESP, GAP, TURN:
  - IDLE: if queue non-empty, pop head.
    - write/read/poll: load ADDR, set WR (write) or RD (read/poll), go ACCESS.
    - reserved op: go RESP with err=1.
  - ACCESS: lasts exactly 1 cycle. RD/WR return to 0 at the next edge.
    - On that edge, if RD, sample DATA into rsp_data.
    - read/write: go RESP.
    - poll:
      - if (sample & mask) == (match & mask): go RESP, err=0.
      - else if reads == POLL_MAX: go RESP, err=1.
      - else go GAP (or straight to ACCESS with RD=1 again when POLL_GAP=0).
  - GAP: count POLL_GAP cycles with RD=0, then re-issue RD at the same ADDR → ACCESS.
  - RESP: rsp_valid=1 for 1 cycle with rsp_data/rsp_err.
    - If the completed access was a read/poll and the next queued op is a write, go TURN (1 idle cycle for DATA turnaround).
    - Otherwise go IDLE. IDLE may pop in the same edge as leaving RESP, allowing back-to-back accesses every 2 cycles.
  - TURN: 1 cycle, all strobes 0, then IDLE.
- Latency, from the accept edge E into an empty queue with FSM IDLE:
  - Strobe high in cycle [E+1, E+2).
  - rsp_valid high in cycle [E+2, E+3).
- Invariants:
  - RD and WR are never high simultaneously.
  - Each strobe lasts exactly one cycle.
  - ADDR holds its value from the strobe cycle until the next access.
  - rsp_data holds its value between pulses.
  - rsp_data=0 on write responses.

Test Plan:
- Write 0x40000004 data 0x64 → one cycle WR=1, ADDR=0x40000004, DATA=0x64; rsp_valid 2 cycles after accept, rsp_err=0, rsp_data=0.
- Read 0x40000008 with bus model returning 0x000000A5 → exactly one RD cycle; rsp_data=0xA5, rsp_err=0; DATA=Z at master otherwise.
- Poll 0x40000000 mask 0x1 match 0x1, model sets bit0 on the 3rd read → 3 RD pulses separated by 2 idle cycles; rsp_data bit0=1, err=0.
- Poll that never matches, POLL_MAX=16 → 16 RD pulses, then rsp_err=1; no further strobes.
- Push 5 commands back-to-back with DEPTH=4 → cmd_ready=0 after 4; read followed by write shows 1 TURN cycle between; 5 responses in order.
- Assert rst_n=0 during a poll GAP → outputs return immediately to reset values, no rsp_valid, busy=0, queue empty.

Source files
------------

// File: rtl/arilla_bus_master.sv
// arillaBus initiator: queues core-side write/read/poll commands and issues
// single-cycle RD/WR strobes on a shared tri-state DATA bus, one response per command.
module arilla_bus_master #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned POLL_GAP = 2,
  parameter int unsigned POLL_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] ADDR,
  output logic        RD,
  output logic        WR,
  inout  wire  [31:0] DATA
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = $clog2(POLL_MAX + 1);
  localparam int unsigned GW = $clog2(POLL_GAP + 2);

  typedef enum logic [1:0] {OP_WR = 2'b00, OP_RD = 2'b01, OP_POLL = 2'b10, OP_RSV = 2'b11} op_e;
  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RESP, S_GAP, S_TURN} state_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop, has_cmd, hit;
  cmd_t             head;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [31:0]      match_q, match_d, mask_q, mask_d;
  logic [RW-1:0]    reads_q, reads_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d, cmd_ready_q, cmd_ready_d;

  assign push    = cmd_valid && cmd_ready_q;
  assign has_cmd = (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign hit     = ((DATA ^ match_q) & mask_q) == '0;

  // Command queue storage; pointers and count are reset with the FSM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {op_e'(cmd_op), cmd_addr, cmd_data, cmd_mask};
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    match_d     = match_q;
    mask_d      = mask_q;
    reads_d     = reads_q;
    gap_d       = gap_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;

    unique case (state_q)
      S_IDLE: pop = has_cmd;
      S_ACCESS: begin
        if (op_q == OP_POLL && !hit && reads_q != RW'(POLL_MAX)) begin
          if (POLL_GAP == 0) begin
            rd_d    = 1'b1;
            reads_d = reads_q + RW'(1);
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = (op_q == OP_WR) ? 32'h0 : DATA;
          rsp_err_d   = (op_q == OP_POLL) && !hit;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(POLL_GAP - 1)) begin
          rd_d    = 1'b1;
          reads_d = reads_q + RW'(1);
          state_d = S_ACCESS;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        // A write right after a read needs one dead cycle so DATA can turn around.
        if (has_cmd) begin
          if ((op_q == OP_RD || op_q == OP_POLL) && head.op == OP_WR) state_d = S_TURN;
          else pop = 1'b1;
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      op_d    = head.op;
      match_d = head.data;
      mask_d  = head.mask;
      wdata_d = head.data;
      if (head.op == OP_RSV) begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = 32'h0;
        rsp_err_d   = 1'b1;
      end else begin
        addr_d  = head.addr;
        wr_d    = (head.op == OP_WR);
        rd_d    = (head.op != OP_WR);
        reads_d = RW'(1);
        state_d = S_ACCESS;
      end
    end

    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    cmd_ready_d = (count_d != CW'(DEPTH));
    busy_d      = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WR;
      match_q     <= '0;
      mask_q      <= '0;
      reads_q     <= '0;
      gap_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      match_q     <= match_d;
      mask_q      <= mask_d;
      reads_q     <= reads_d;
      gap_q       <= gap_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign ADDR      = addr_q;
  assign RD        = rd_q;
  assign WR        = wr_q;
  assign DATA      = wr_q ? wdata_q : 'z;

endmodule

// File: tb/tb_arilla_bus_master.sv
// Scoreboard bench for arilla_bus_master: a small peripheral model answers reads,
// a negedge monitor checks every strobe and response against queued expectations.
module tb_arilla_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = '0, cmd_data = '0, cmd_mask = '0;
  logic        rsp_valid, rsp_err, busy, RD, WR;
  logic [31:0] rsp_data, ADDR;
  wire  [31:0] data_bus;

  always #5 clk = ~clk;

  arilla_bus_master #(.DEPTH(4), .POLL_GAP(2), .POLL_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .ADDR(ADDR), .RD(RD), .WR(WR), .DATA(data_bus)
  );

  // Peripheral model: 0x08 returns 0xA5, status at 0x00 gets bit0 on its 3rd read.
  int          cyc = 0;
  int          status_cnt = 0;
  int          status_base = 0;
  logic [31:0] model_rd;

  always_comb begin
    if (ADDR == 32'h4000_0008)      model_rd = 32'h0000_00A5;
    else if (ADDR == 32'h4000_0000) model_rd = ((status_cnt - status_base) >= 2) ? 32'h1 : 32'h0;
    else                            model_rd = 32'hDEAD_0000;
  end

  assign data_bus = RD ? model_rd : 32'bz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (RD && ADDR == 32'h4000_0000) status_cnt <= status_cnt + 1;
  end

  typedef struct { bit is_wr; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct { logic [31:0] data; bit err; } rsp_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  int   stb_cyc[$];
  int   rsp_cyc[$];
  int   n_stb = 0, n_rsp = 0;
  int   tests = 0, fails = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: compares strobes and responses as they appear.
  bit          prev_stb = 1'b0;
  logic [31:0] last_rsp_data = '0;
  always @(negedge clk) begin
    bus_t eb;
    rsp_t er;
    if (!rst_n) begin
      prev_stb      = 1'b0;
      last_rsp_data = '0;
    end else begin
      if (RD || WR) begin
        check("strobe_exclusive", 32'(RD && WR), 32'h0);
        check("strobe_one_cycle", 32'(prev_stb), 32'h0);
        stb_cyc.push_back(cyc);
        n_stb++;
        if (exp_bus.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_strobe: RD=%0b WR=%0b ADDR=0x%08h at cycle %0d", RD, WR, ADDR, cyc);
        end else begin
          eb = exp_bus.pop_front();
          check("strobe_kind_wr", 32'(WR), 32'(eb.is_wr));
          check("strobe_addr", ADDR, eb.addr);
          if (eb.is_wr) check("strobe_wdata", data_bus, eb.data);
        end
      end
      prev_stb = RD || WR;
      if (rsp_valid) begin
        rsp_cyc.push_back(cyc);
        n_rsp++;
        if (exp_rsp.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: data=0x%08h err=%0b at cycle %0d", rsp_data, rsp_err, cyc);
        end else begin
          er = exp_rsp.pop_front();
          check("rsp_data", rsp_data, er.data);
          check("rsp_err", 32'(rsp_err), 32'(er.err));
        end
        last_rsp_data = rsp_data;
      end else begin
        check("rsp_data_hold", rsp_data, last_rsp_data);
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] m, output int acc);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: cmd_ready stuck at 0 for op %0d", op);
      cmd_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      #1 acc = cyc;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (n_rsp < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (n_rsp < n) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: got %0d responses, expected %0d", n_rsp, n);
    end
  endtask

  task automatic exp_b(input bit w, input logic [31:0] a, input logic [31:0] d);
    bus_t e;
    e.is_wr = w; e.addr = a; e.data = d;
    exp_bus.push_back(e);
  endtask

  task automatic exp_r(input logic [31:0] d, input bit err);
    rsp_t e;
    e.data = d; e.err = err;
    exp_rsp.push_back(e);
  endtask

  initial begin
    int acc, bs, br, k;
    int a[6];

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ADDR", ADDR, 32'h0);
    check("rst_RD", 32'(RD), 32'h0);
    check("rst_WR", 32'(WR), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write
    bs = n_stb; br = n_rsp;
    exp_b(1'b1, 32'h4000_0004, 32'h64);
    exp_r(32'h0, 1'b0);
    push(2'b00, 32'h4000_0004, 32'h64, 32'h0, acc);
    idle();
    wait_rsp(br + 1);
    check("wr_strobe_latency", 32'(stb_cyc[bs]), 32'(acc + 1));
    check("wr_rsp_latency", 32'(rsp_cyc[br]), 32'(acc + 2));
    check("wr_strobe_count", 32'(n_stb - bs), 32'h1);
    @(negedge clk);
    check("wr_busy_after", 32'(busy), 32'h0);

    // Single read
    bs = n_stb; br = n_rsp;
    exp_b(1'b0, 32'h4000_0008, 32'h0);
    exp_r(32'hA5, 1'b0);
    push(2'b01, 32'h4000_0008, 32'h0, 32'h0, acc);
    idle();
    wait_rsp(br + 1);
    check("rd_strobe_latency", 32'(stb_cyc[bs]), 32'(acc + 1));
    check("rd_rsp_latency", 32'(rsp_cyc[br]), 32'(acc + 2));
    check("rd_strobe_count", 32'(n_stb - bs), 32'h1);
    repeat (2) @(negedge clk);

    // Poll that matches on the third read
    status_base = status_cnt;
    bs = n_stb; br = n_rsp;
    repeat (3) exp_b(1'b0, 32'h4000_0000, 32'h0);
    exp_r(32'h1, 1'b0);
    push(2'b10, 32'h4000_0000, 32'h1, 32'h1, acc);
    idle();
    wait_rsp(br + 1);
    check("poll_strobe_count", 32'(n_stb - bs), 32'h3);
    check("poll_gap_1", 32'(stb_cyc[bs + 1] - stb_cyc[bs]), 32'h3);
    check("poll_gap_2", 32'(stb_cyc[bs + 2] - stb_cyc[bs + 1]), 32'h3);
    check("poll_rsp_after_last", 32'(rsp_cyc[br] - stb_cyc[bs + 2]), 32'h1);
    repeat (2) @(negedge clk);

    // Poll that never matches: POLL_MAX reads, then error
    bs = n_stb; br = n_rsp;
    repeat (16) exp_b(1'b0, 32'h4000_0004, 32'h0);
    exp_r(32'hDEAD_0000, 1'b1);
    push(2'b10, 32'h4000_0004, 32'h5A, 32'hFF, acc);
    idle();
    wait_rsp(br + 1);
    repeat (30) @(negedge clk);
    check("timeout_strobe_count", 32'(n_stb - bs), 32'd16);
    check("timeout_busy_after", 32'(busy), 32'h0);

    // Queue fill behind a slow poll, read->write turnaround, reserved op
    status_base = status_cnt;
    bs = n_stb; br = n_rsp;
    repeat (3) exp_b(1'b0, 32'h4000_0000, 32'h0);
    exp_b(1'b0, 32'h4000_0008, 32'h0);
    exp_b(1'b1, 32'h4000_0004, 32'h11);
    exp_b(1'b1, 32'h4000_0004, 32'h22);
    exp_b(1'b0, 32'h4000_0008, 32'h0);
    exp_r(32'h1, 1'b0);
    exp_r(32'hA5, 1'b0);
    exp_r(32'h0, 1'b0);
    exp_r(32'h0, 1'b0);
    exp_r(32'hA5, 1'b0);
    exp_r(32'h0, 1'b1);
    push(2'b10, 32'h4000_0000, 32'h1, 32'h1, a[0]);
    push(2'b01, 32'h4000_0008, 32'h0, 32'h0, a[1]);
    push(2'b00, 32'h4000_0004, 32'h11, 32'h0, a[2]);
    push(2'b00, 32'h4000_0004, 32'h22, 32'h0, a[3]);
    push(2'b01, 32'h4000_0008, 32'h0, 32'h0, a[4]);
    check("full_cmd_ready", 32'(cmd_ready), 32'h0);
    push(2'b11, 32'h4000_0000, 32'h0, 32'h0, a[5]);
    idle();
    check("fill_back_to_back", 32'(a[4] - a[1]), 32'h3);
    check("full_stall", 32'(a[5] - a[4] > 1), 32'h1);
    wait_rsp(br + 6);
    check("batch_strobe_count", 32'(n_stb - bs), 32'h7);
    check("poll_to_read", 32'(stb_cyc[bs + 3] - stb_cyc[bs + 2]), 32'h2);
    check("read_to_write_turn", 32'(stb_cyc[bs + 4] - stb_cyc[bs + 3]), 32'h4);
    check("write_to_write", 32'(stb_cyc[bs + 5] - stb_cyc[bs + 4]), 32'h2);
    check("write_to_read", 32'(stb_cyc[bs + 6] - stb_cyc[bs + 5]), 32'h2);
    repeat (4) @(negedge clk);
    check("exp_bus_drained", 32'(exp_bus.size()), 32'h0);
    check("exp_rsp_drained", 32'(exp_rsp.size()), 32'h0);

    // Reset while a poll sits in its gap with another command queued
    bs = n_stb;
    repeat (16) exp_b(1'b0, 32'h4000_0004, 32'h0);
    exp_r(32'hDEAD_0000, 1'b1);
    exp_b(1'b0, 32'h4000_0008, 32'h0);
    exp_r(32'hA5, 1'b0);
    push(2'b10, 32'h4000_0004, 32'h5A, 32'hFF, acc);
    push(2'b01, 32'h4000_0008, 32'h0, 32'h0, acc);
    idle();
    k = 0;
    while (n_stb < bs + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("gap_rd_low", 32'(RD), 32'h0);
    check("gap_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    exp_bus.delete();
    exp_rsp.delete();
    check("midrst_ADDR", ADDR, 32'h0);
    check("midrst_RD", 32'(RD), 32'h0);
    check("midrst_WR", 32'(WR), 32'h0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bs = n_stb; br = n_rsp;
    repeat (40) @(negedge clk);
    check("postrst_no_strobe", 32'(n_stb - bs), 32'h0);
    check("postrst_no_rsp", 32'(n_rsp - br), 32'h0);
    check("postrst_busy", 32'(busy), 32'h0);
    check("postrst_cmd_ready", 32'(cmd_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
